// File: rtl/counter_pkg.sv
// Shared definitions for the counter family: direction encoding and load clamping.
package counter_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Wide enough for any counter up to 32 bits; callers cast to and from their own width.
    localparam int unsigned CLAMP_W = 32;

    function automatic logic [CLAMP_W-1:0] clamp_load(input logic [CLAMP_W-1:0] value,
                                                      input logic [CLAMP_W-1:0] max);
        return (value > max) ? max : value;
    endfunction

endpackage

// File: rtl/counter_boundary_detect.sv
// Flags when the count sits on the boundary for the current direction (MAX_VAL up, 0 down).
module counter_boundary_detect
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MAX_VAL = 15
) (
    input  logic [WIDTH-1:0] q,
    input  logic             up_dn,
    output logic             at_bound
);

    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX_VAL);

    always_comb begin
        at_bound = (up_dn == DIR_UP) ? (q == MAX_Q) : (q == '0);
    end

endmodule

// File: rtl/sync_param_loadable_updown_counter.sv
// WIDTH-bit modulo-(MAX_VAL+1) loadable up/down counter with lookahead tc and wrap pulse.
// Define COUNTER_SATURATE_EN to hold at the boundary instead of wrapping.
module sync_param_loadable_updown_counter
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MAX_VAL = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_en,
    input  logic [WIDTH-1:0] data,
    input  logic             en,
    input  logic             up_dn,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrapped
);

    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX_VAL);

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrapped_q, wrapped_d;
    logic             at_bound;
    logic [WIDTH-1:0] load_val;

    counter_boundary_detect #(
        .WIDTH   (WIDTH),
        .MAX_VAL (MAX_VAL)
    ) u_bound (
        .q        (count_q),
        .up_dn    (up_dn),
        .at_bound (at_bound)
    );

    assign load_val = WIDTH'(clamp_load(CLAMP_W'(data), CLAMP_W'(MAX_VAL)));

    // Lookahead: high the cycle before a counting edge crosses the boundary.
    assign tc = en & ~load_en & at_bound;

    always_comb begin
        count_d = count_q;
        if (load_en) begin
            count_d = load_val;
        end else if (en) begin
            if (at_bound) begin
`ifdef COUNTER_SATURATE_EN
                count_d = count_q;
`else
                count_d = (up_dn == DIR_UP) ? '0 : MAX_Q;
`endif
            end else begin
                count_d = (up_dn == DIR_DOWN) ? count_q - 1'b1 : count_q + 1'b1;
            end
        end
    end

`ifdef COUNTER_SATURATE_EN
    assign wrapped_d = 1'b0;
`else
    assign wrapped_d = tc;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q   <= '0;
            wrapped_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            wrapped_q <= wrapped_d;
        end
    end

    assign q       = count_q;
    assign wrapped = wrapped_q;

endmodule

// File: tb/tb_sync_param_loadable_updown_counter.sv
// Self-checking bench: two cascaded WIDTH=4, MAX_VAL=9 counters against an arithmetic model.
// Follows COUNTER_SATURATE_EN when the build defines it.
module tb_sync_param_loadable_updown_counter;

    localparam int unsigned W    = 4;
    localparam int          MAXV = 9;
`ifdef COUNTER_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic         clk;
    logic         rst;
    logic         load_en, en, up_dn;
    logic [W-1:0] data;
    logic         load_en1;
    logic [W-1:0] data1;
    logic [W-1:0] q0, q1;
    logic         tc0, tc1, w0, w1;

    int n_cmp = 0;
    int n_err = 0;

    // Model state
    int m_q0 = 0, m_w0 = 0, m_q1 = 0, m_w1 = 0;
    bit m_valid = 1'b0;

    sync_param_loadable_updown_counter #(.WIDTH(W), .MAX_VAL(MAXV)) u_stage0 (
        .clk     (clk),
        .rst     (rst),
        .load_en (load_en),
        .data    (data),
        .en      (en),
        .up_dn   (up_dn),
        .q       (q0),
        .tc      (tc0),
        .wrapped (w0)
    );

    sync_param_loadable_updown_counter #(.WIDTH(W), .MAX_VAL(MAXV)) u_stage1 (
        .clk     (clk),
        .rst     (rst),
        .load_en (load_en1),
        .data    (data1),
        .en      (tc0),
        .up_dn   (up_dn),
        .q       (q1),
        .tc      (tc1),
        .wrapped (w1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int model_tc(input int mq, input bit e, input bit ld, input bit up);
        return (e && !ld && (up ? (mq == MAXV) : (mq == 0))) ? 1 : 0;
    endfunction

    task automatic model_edge(input int mq, input bit r, input bit ld, input bit e, input bit up,
                              input int d, output int nq, output int nw);
        bit at_edge;
        nq = mq;
        nw = 0;
        if (!r) begin
            nq = 0;
        end else if (ld) begin
            nq = (d > MAXV) ? MAXV : d;
        end else if (e) begin
            at_edge = up ? (mq == MAXV) : (mq == 0);
            if (SAT) begin
                nq = at_edge ? mq : (up ? mq + 1 : mq - 1);
            end else begin
                nq = up ? (mq + 1) % (MAXV + 1) : (mq + MAXV) % (MAXV + 1);
                nw = at_edge ? 1 : 0;
            end
        end
    endtask

    // Check tc with current inputs, clock once, then check registered outputs of both stages.
    task automatic step(input string tag);
        int e1, nq, nw;
        #1;
        e1 = model_tc(m_q0, en, load_en, up_dn);
        if (m_valid) begin
            check_value({tag, ".tc0"}, 32'(tc0), 32'(e1));
            check_value({tag, ".tc1"}, 32'(tc1), 32'(model_tc(m_q1, e1 != 0, load_en1, up_dn)));
        end
        @(posedge clk);
        model_edge(m_q1, rst, load_en1, e1 != 0, up_dn, int'(data1), nq, nw);
        m_q1 = nq;
        m_w1 = nw;
        model_edge(m_q0, rst, load_en, en, up_dn, int'(data), nq, nw);
        m_q0 = nq;
        m_w0 = nw;
        if (!rst) m_valid = 1'b1;
        #1;
        if (m_valid) begin
            check_value({tag, ".q0"}, 32'(q0), 32'(m_q0));
            check_value({tag, ".w0"}, 32'(w0), 32'(m_w0));
            check_value({tag, ".q1"}, 32'(q1), 32'(m_q1));
            check_value({tag, ".w1"}, 32'(w1), 32'(m_w1));
        end
    endtask

    initial begin
        load_en1 = 1'b0;
        data1    = '0;

        // Reset overrides a simultaneous load and count
        rst = 1'b0; load_en = 1'b1; en = 1'b1; up_dn = 1'b1; data = 4'd5;
        repeat (2) step("reset");
        check_value("reset.q_zero", 32'(q0), 32'd0);
        rst = 1'b1; load_en = 1'b0;
        step("count_start");
        check_value("count_start.q", 32'(q0), 32'd1);

        // Load 7 then count up through the wrap
        load_en = 1'b1; data = 4'd7;
        step("load7");
        load_en = 1'b0; en = 1'b1; up_dn = 1'b1;
        repeat (3) step("up_wrap");
        if (!SAT) begin
            check_value("up_wrap.q", 32'(q0), 32'd0);
            check_value("up_wrap.pulse", 32'(w0), 32'd1);
        end

        // Load 1 then count down through the wrap, then pause
        load_en = 1'b1; data = 4'd1; up_dn = 1'b0;
        step("load1");
        load_en = 1'b0;
        repeat (2) step("down_wrap");
        en = 1'b0;
        repeat (2) step("hold");
        check_value("hold.tc", 32'(tc0), 32'd0);

        // Clamped load beats enable
        load_en = 1'b1; en = 1'b1; up_dn = 1'b1; data = 4'd12;
        step("clamp");
        check_value("clamp.q", 32'(q0), 32'd9);
        en = 1'b0; load_en = 1'b0;
        step("clamp_after");

        // Two-digit cascade counting 0..99 and rolling over
        rst = 1'b0;
        step("cascade_rst");
        rst = 1'b1; en = 1'b1; up_dn = 1'b1;
        repeat (99) step("cascade");
        #1;
        check_value("cascade99.q0", 32'(q0), 32'd9);
        check_value("cascade99.q1", 32'(q1), 32'(SAT ? 32'd9 : 32'd9));
        check_value("cascade99.tc1", 32'(tc1), 32'd1);
        step("cascade_roll");
        if (!SAT) begin
            check_value("cascade_roll.q0", 32'(q0), 32'd0);
            check_value("cascade_roll.q1", 32'(q1), 32'd0);
        end

`ifdef COUNTER_SATURATE_EN
        load_en = 1'b1; data = 4'd8;
        step("sat_load8");
        load_en = 1'b0; en = 1'b1; up_dn = 1'b1;
        repeat (3) step("sat_up");
        check_value("sat_up.q", 32'(q0), 32'd9);
        load_en = 1'b1; data = 4'd0;
        step("sat_load0");
        load_en = 1'b0; up_dn = 1'b0;
        repeat (2) step("sat_down");
        check_value("sat_down.q", 32'(q0), 32'd0);
`endif

        // Randomised sweep
        for (int i = 0; i < 64; i++) begin
            rst      = ($urandom_range(0, 7) != 0);
            load_en  = ($urandom_range(0, 3) == 0);
            en       = ($urandom_range(0, 3) != 0);
            up_dn    = 1'($urandom);
            data     = W'($urandom);
            load_en1 = ($urandom_range(0, 7) == 0);
            data1    = W'($urandom);
            step("random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
